// File: rtl/camera_capture_rgb332_if.sv
// Camera byte stream in, RGB332 frame-buffer write port and frame status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the camera cannot be stalled and the RAM always accepts writes.
interface camera_capture_rgb332_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        CAM_DATA;
    logic              CAM_HREF;
    logic              CAM_VSYNC;
    logic [7:0]        PIXEL_DATA;
    logic [ADDR_W-1:0] W_ADDR;
    logic              W_EN;
    logic              FRAME_DONE;
    logic              FRAME_ERR;

    // Camera / bench side: drives the sensor bus, observes the RAM write port.
    modport master (
        output CAM_DATA, CAM_HREF, CAM_VSYNC,
        input  PIXEL_DATA, W_ADDR, W_EN, FRAME_DONE, FRAME_ERR
    );

    // Capture block side.
    modport slave (
        input  CAM_DATA, CAM_HREF, CAM_VSYNC,
        output PIXEL_DATA, W_ADDR, W_EN, FRAME_DONE, FRAME_ERR
    );
endinterface

// File: rtl/camera_capture_rgb332.sv
// Packs the camera RGB565 byte stream to RGB332 and writes it into the frame-buffer RAM.
// Latency: W_EN/W_ADDR/PIXEL_DATA registered 1 CLK after the low byte of each pixel.
// Backpressure: none; out-of-window pixels are dropped and flagged via FRAME_ERR.
module camera_capture_rgb332 #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 15
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    camera_capture_rgb332_if.slave  bus
);
    localparam int X_W = $clog2(WIDTH + 1);
    localparam int Y_W = $clog2(HEIGHT + 1);

    localparam logic [X_W-1:0]    X_MAX  = X_W'(WIDTH);
    localparam logic [Y_W-1:0]    Y_MAX  = Y_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] L_STEP = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              err_q, err_d;
    logic              href_q, href_d;
    logic [7:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;

    // Next-state, datapath and output decode. The line-end update is computed
    // before the frame-end check so a coincident HREF fall / VSYNC rise sees the new y.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        line_base_d = line_base_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        err_d       = err_q;
        href_d      = 1'b0;
        pix_d       = pix_q;
        addr_d      = addr_q;
        wen_d       = 1'b0;
        done_d      = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.CAM_VSYNC) begin
                    state_d = SYNC;
                end
            end

            SYNC: begin
                if (!bus.CAM_VSYNC) begin
                    state_d     = ACTIVE;
                    x_d         = '0;
                    y_d         = '0;
                    line_base_d = '0;
                    phase_d     = 1'b0;
                    err_d       = 1'b0;
                end
            end

            ACTIVE: begin
                href_d = bus.CAM_HREF;
                if (bus.CAM_HREF && !bus.CAM_VSYNC) begin
                    if (!phase_q) begin
                        hi_d    = bus.CAM_DATA;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < X_MAX && y_q < Y_MAX) begin
                            wen_d  = 1'b1;
                            pix_d  = {hi_q[7:5], hi_q[2:0], bus.CAM_DATA[4:3]};
                            addr_d = line_base_q + ADDR_W'(x_q);
                        end else begin
                            err_d = 1'b1;
                        end
                        // x saturates at WIDTH so excess pixels never wrap onto the next line
                        if (x_q < X_MAX) begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end else if (href_q && !bus.CAM_HREF) begin
                    // Empty lines do not advance y; line_base stops once y saturates
                    if (x_q != '0 && y_q < Y_MAX) begin
                        y_d         = y_q + 1'b1;
                        line_base_d = line_base_q + L_STEP;
                    end
                    // Short/long line or odd trailing byte
                    if (x_q != X_MAX || phase_q) begin
                        err_d = 1'b1;
                    end
                    x_d     = '0;
                    phase_d = 1'b0;
                end

                if (bus.CAM_VSYNC) begin
                    state_d = SYNC;
                    href_d  = 1'b0;
                    done_d  = 1'b1;
                    ferr_d  = err_d || (y_d != Y_MAX);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered write-port / status outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            err_q       <= 1'b0;
            href_q      <= 1'b0;
            pix_q       <= '0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            line_base_q <= line_base_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            err_q       <= err_d;
            href_q      <= href_d;
            pix_q       <= pix_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
        end
    end

    assign bus.PIXEL_DATA = pix_q;
    assign bus.W_ADDR     = addr_q;
    assign bus.W_EN       = wen_q;
    assign bus.FRAME_DONE = done_q;
    assign bus.FRAME_ERR  = ferr_q;

endmodule

// File: tb/tb_camera_capture_rgb332.sv
// Directed bench for camera_capture_rgb332: full frame, packing, long/short lines, reset, sync gating.
// Latency: checks outputs 2 time units after each rising edge.
// Backpressure: n/a; the bench drives the camera bus freely.
module tb_camera_capture_rgb332;
    logic CLK = 1'b0;
    logic RESET_N;

    always #5 CLK = ~CLK;

    camera_capture_rgb332_if #(.ADDR_W(15)) bus ();

    camera_capture_rgb332 #(
        .WIDTH  (176),
        .HEIGHT (144),
        .ADDR_W (15)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int dc;
    logic [14:0] wa_q[$];
    logic [7:0]  wd_q[$];

    // Write/frame-pulse monitor on the falling edge, away from the stimulus instants.
    always @(negedge CLK) begin
        if (bus.W_EN === 1'b1) begin
            wa_q.push_back(bus.W_ADDR);
            wd_q.push_back(bus.PIXEL_DATA);
        end
        if (bus.FRAME_DONE === 1'b1) begin
            done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Expected RGB332 for hi byte n[7:0] and lo byte 8'h18 (B565[4:3]=2'b11).
    function automatic logic [7:0] pack(input int n);
        logic [7:0] v;
        v = 8'(n);
        return {v[7:5], v[2:0], 2'b11};
    endfunction

    // nbytes with HREF high (hi=start+k, lo=8'h18), then four HREF-low cycles.
    task automatic send_line(input int nbytes, input int start);
        for (int i = 0; i < nbytes; i++) begin
            step();
            bus.CAM_HREF = 1'b1;
            bus.CAM_DATA = (i % 2 == 0) ? 8'(start + i / 2) : 8'h18;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            bus.CAM_HREF = 1'b0;
        end
    endtask

    task automatic frame_start();
        step();
        bus.CAM_HREF  = 1'b0;
        bus.CAM_VSYNC = 1'b1;
        step();
        step();
        step();
        bus.CAM_VSYNC = 1'b0;
        step();
        step();
    endtask

    task automatic frame_end(input logic exp_err, input string tag);
        step();
        bus.CAM_HREF  = 1'b0;
        bus.CAM_VSYNC = 1'b1;
        step();
        check({tag, "_done"}, bus.FRAME_DONE, 1);
        check({tag, "_err"}, bus.FRAME_ERR, exp_err);
        step();
        check({tag, "_done_clr"}, bus.FRAME_DONE, 0);
    endtask

    initial begin
        bus.CAM_DATA  = 8'h00;
        bus.CAM_HREF  = 1'b0;
        bus.CAM_VSYNC = 1'b0;
        RESET_N       = 1'b0;
        step();
        step();
        step();
        check("rst_wen",  bus.W_EN, 0);
        check("rst_addr", bus.W_ADDR, 0);
        check("rst_pix",  bus.PIXEL_DATA, 0);
        check("rst_done", bus.FRAME_DONE, 0);
        check("rst_ferr", bus.FRAME_ERR, 0);
        RESET_N = 1'b1;

        // HREF traffic before any VSYNC after reset
        send_line(352, 0);
        check("pre_vsync_writes", wa_q.size(), 0);
        check("pre_vsync_done", done_cnt, 0);

        // Full 176x144 frame, pixel n hi=n[7:0]
        frame_start();
        for (int l = 0; l < 144; l++) begin
            send_line(352, l * 176);
        end
        frame_end(1'b0, "full");
        check("full_count", wa_q.size(), 25344);
        for (int i = 0; i < wa_q.size(); i++) begin
            check("full_addr", wa_q[i], i);
            check("full_data", wd_q[i], pack(i));
        end
        wa_q.delete();
        wd_q.delete();

        // HREF while VSYNC high: no writes, no frame pulse
        dc = done_cnt;
        bus.CAM_VSYNC = 1'b1;
        send_line(352, 0);
        check("vsync_hi_writes", wa_q.size(), 0);
        check("vsync_hi_done", done_cnt, dc);

        // Packing and write latency
        frame_start();
        step();
        bus.CAM_HREF = 1'b1;
        bus.CAM_DATA = 8'hE7;
        step();
        check("pk_hi_nowen", bus.W_EN, 0);
        bus.CAM_DATA = 8'h18;
        step();
        check("pk_ff_wen",  bus.W_EN, 1);
        check("pk_ff_data", bus.PIXEL_DATA, 8'hFF);
        check("pk_ff_addr", bus.W_ADDR, 0);
        bus.CAM_DATA = 8'h00;
        step();
        check("pk_hi2_nowen", bus.W_EN, 0);
        bus.CAM_DATA = 8'h00;
        step();
        check("pk_00_wen",  bus.W_EN, 1);
        check("pk_00_data", bus.PIXEL_DATA, 8'h00);
        check("pk_00_addr", bus.W_ADDR, 1);
        bus.CAM_HREF = 1'b0;
        step();
        check("pk_idle_wen",  bus.W_EN, 0);
        check("pk_hold_data", bus.PIXEL_DATA, 8'h00);
        check("pk_hold_addr", bus.W_ADDR, 1);
        frame_end(1'b1, "pk");
        wa_q.delete();
        wd_q.delete();

        // Long line (180 px) then a normal line
        frame_start();
        send_line(360, 0);
        send_line(352, 0);
        frame_end(1'b1, "long");
        check("long_count", wa_q.size(), 352);
        check("long_last_addr", wa_q[175], 175);
        check("long_last_data", wd_q[175], pack(175));
        check("long_next_addr", wa_q[176], 176);
        check("long_next_data", wd_q[176], pack(0));
        check("long_end_addr",  wa_q[351], 351);
        wa_q.delete();
        wd_q.delete();

        // Short line with odd trailing byte, then a normal line
        frame_start();
        send_line(351, 0);
        send_line(352, 0);
        frame_end(1'b1, "short");
        check("short_count", wa_q.size(), 351);
        check("short_last_addr", wa_q[174], 174);
        check("short_next_addr", wa_q[175], 176);
        check("short_next_data", wd_q[175], pack(0));
        wa_q.delete();
        wd_q.delete();

        // Reset in the middle of line 50
        frame_start();
        for (int l = 0; l < 50; l++) begin
            send_line(352, 0);
        end
        for (int i = 0; i < 100; i++) begin
            step();
            bus.CAM_HREF = 1'b1;
            bus.CAM_DATA = (i % 2 == 0) ? 8'(i / 2) : 8'h18;
        end
        step();
        RESET_N = 1'b0;
        bus.CAM_DATA = 8'h55;
        step();
        check("mid_rst_wen",  bus.W_EN, 0);
        check("mid_rst_addr", bus.W_ADDR, 0);
        check("mid_rst_pix",  bus.PIXEL_DATA, 0);
        check("mid_count", wa_q.size(), 8850);
        check("mid_last_addr", wa_q[8849], 8849);
        wa_q.delete();
        wd_q.delete();
        step();
        RESET_N = 1'b1;
        send_line(352, 0);
        send_line(352, 0);
        check("post_rst_writes", wa_q.size(), 0);
        dc = done_cnt;
        frame_start();
        check("post_rst_done", done_cnt, dc);
        send_line(352, 0);
        check("post_rst_count", wa_q.size(), 176);
        check("post_rst_first", wa_q[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
